// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Raster timing generator. Produces sync, data-enable and pixel
//               colour, with an image window fetched from external memory.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int unsigned ScreenX            = 1366,
    parameter int unsigned ScreenY            = 768,
    parameter int unsigned BlankingHorizontal = 50,
    parameter int unsigned BlankingVertical   = 12,
    parameter int unsigned HSyncStart         = 8,
    parameter int unsigned HSyncWidth         = 16,
    parameter int unsigned VSyncStart         = 2,
    parameter int unsigned VSyncWidth         = 4,
    parameter int unsigned ImgW               = 100,
    parameter int unsigned ImgH               = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        img_rd_en,
    output logic [13:0] img_addr,
    input  logic [23:0] img_data,
    output logic        HSync,
    output logic        VSync,
    output logic        DataEnable,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = ScreenX + BlankingHorizontal;
    localparam int unsigned V_TOTAL = ScreenY + BlankingVertical;
    localparam int unsigned HS_BEG  = ScreenX + HSyncStart;
    localparam int unsigned HS_END  = HS_BEG + HSyncWidth;
    localparam int unsigned VS_BEG  = ScreenY + VSyncStart;
    localparam int unsigned VS_END  = VS_BEG + VSyncWidth;
    localparam int unsigned X_MID   = ScreenX / 2;
    localparam int unsigned Y_MID   = ScreenY / 2;

    // Stage 0: raster counters and image pixel index
    logic [10:0] x;
    logic [9:0]  y;
    logic [13:0] pix_idx;
    logic [31:0] xe;
    logic [31:0] ye;
    logic        x_last;
    logic        y_last;
    logic        in_img;

    assign xe     = 32'(x);
    assign ye     = 32'(y);
    assign x_last = (xe == H_TOTAL - 1);
    assign y_last = (ye == V_TOTAL - 1);
    assign in_img = (xe < ImgW) && (ye < ImgH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            pix_idx <= '0;
        end else begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 10'd1;
            end else begin
                x <= x + 11'd1;
            end
            if (x_last && y_last) begin
                pix_idx <= '0;
            end else if (in_img) begin
                pix_idx <= pix_idx + 14'd1;
            end
        end
    end

    // Counters sit at (0,0) during reset, so the strobe is gated to stay quiet
    assign img_rd_en = rst_n & in_img;
    assign img_addr  = pix_idx;

    // Stage 1: registered controls, aligned with the returning img_data
    logic de1;
    logic hs1;
    logic vs1;
    logic fs1;
    logic cross1;
    logic win1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de1    <= 1'b0;
            hs1    <= 1'b0;
            vs1    <= 1'b0;
            fs1    <= 1'b0;
            cross1 <= 1'b0;
            win1   <= 1'b0;
        end else begin
            de1    <= (xe < ScreenX) && (ye < ScreenY);
            hs1    <= (xe >= HS_BEG) && (xe < HS_END);
            vs1    <= (ye >= VS_BEG) && (ye < VS_END);
            fs1    <= (x == '0) && (y == '0);
            cross1 <= (xe == X_MID) || (ye == Y_MID);
            win1   <= in_img;
        end
    end

    // Stage 2: output registers
    logic [23:0] colour;

    always_comb begin
        colour = 24'h000000;
        if (de1) begin
            if (cross1) begin
                colour = 24'hFFFFFF;
            end else if (win1) begin
                colour = img_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            HSync       <= 1'b1;
            VSync       <= 1'b1;
            DataEnable  <= 1'b0;
            frame_start <= 1'b0;
            Red         <= '0;
            Green       <= '0;
            Blue        <= '0;
        end else begin
            HSync       <= ~hs1;
            VSync       <= ~vs1;
            DataEnable  <= de1;
            frame_start <= fs1;
            Red         <= colour[23:16];
            Green       <= colour[15:8];
            Blue        <= colour[7:0];
        end
    end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameters: ScreenX=1366, active pixels/line; ScreenY=768, active lines/frame; BlankingHorizontal=50, blank pixels/line; BlankingVertical=12, blank lines/frame; HSyncStart=8, HSync offset after active; HSyncWidth=16, HSync length; VSyncStart=2, VSync offset after active; VSyncWidth=4, VSync length; ImgW=100, image window width; ImgH=100, image window height.
REQ-002 SHALL have ports: clk  in  1  dot clock, all logic on rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: img_rd_en  out  1  image memory read strobe; img_addr  out  14  image pixel index; img_data  in  24  {R,G,B} returned exactly 1 cycle after img_rd_en.
REQ-004 SHALL have ports: HSync  out  1  active-low; VSync  out  1  active-low; DataEnable  out  1  active-high; Red/Green/Blue  out  8 each  pixel colour; frame_start  out  1  one-cycle pulse.

Function
REQ-005 SHALL keep internal counters x (11 bit) and y (10 bit); x counts 0..ScreenX+BlankingHorizontal-1 (1415), then wraps to 0.
REQ-006 SHALL increment y only in the cycle x wraps; y counts 0..ScreenY+BlankingVertical-1 (779), then wraps to 0.
REQ-007 SHALL use a 3-stage pipeline: S0 counters, S1 memory request plus registered controls, S2 registered outputs; every output reflects the S0 (x,y) of 2 cycles earlier.
REQ-008 SHALL assert DataEnable iff x<ScreenX and y<ScreenY.
REQ-009 SHALL drive HSync=0 iff ScreenX+HSyncStart <= x < ScreenX+HSyncStart+HSyncWidth (x 1374..1389), on every line including vertical blank.
REQ-010 SHALL drive VSync=0 iff ScreenY+VSyncStart <= y < ScreenY+VSyncStart+VSyncWidth (y 770..773), for the whole of each such line.
REQ-011 SHALL pulse frame_start for the single output cycle corresponding to (x,y)=(0,0).
REQ-012 SHALL assert img_rd_en in S0 iff x<ImgW and y<ImgH; img_addr SHALL equal an internal pixel index valid in that cycle.
REQ-013 SHALL increment the pixel index by 1 after each img_rd_en; index SHALL reset to 0 when x=0 and y=0, so frame N+1 restarts at 0 even if frame N was truncated.
REQ-014 SHALL sample img_data in S1 (one cycle after img_rd_en) and carry it to S2 aligned with its (x,y).
REQ-015 SHALL select colour, highest priority first: x==ScreenX/2 (683) or y==ScreenY/2 (384) -> FFFFFF; inside image window -> img_data; otherwise -> 000000.
REQ-016 SHALL force Red/Green/Blue=0 whenever DataEnable=0, overriding REQ-015.
REQ-017 SHALL keep arithmetic unsigned; compare constants SHALL be computed at elaboration with no truncation into the counter widths.

Reset
REQ-018 SHALL, while rst_n=0, asynchronously force x=0, y=0, pixel index=0, all pipeline registers cleared, HSync=1, VSync=1, DataEnable=0, RGB=0, frame_start=0, img_rd_en=0, img_addr=0.
REQ-019 SHALL, on the first rising edge after rst_n deasserts, start S0 at (0,0); first frame_start and first DataEnable=1 SHALL appear at output in cycle 2 after release.
REQ-020 SHALL, on reset asserted mid-frame, abandon the frame with no partial sync pulse extended past reset; after release SHALL restart exactly as REQ-019.

Verification
REQ-021 Release reset, count cycles -> DataEnable first high at cycle 2 with frame_start=1; high for 1366 cycles, low for 50; line period 1416.
REQ-022 Run one full line -> HSync low exactly 16 cycles beginning 1374 cycles after the DataEnable rising edge; frame period 1416*780=1104480 cycles; VSync low for 4*1416 cycles starting at line 770.
REQ-023 Memory model returning img_data=addr-derived colour -> img_addr 0..99 on line 0, 100..199 on line 1, last 9999 at (99,99); next frame restarts at 0; RGB at output matches the model data for the same (x,y).
REQ-024 Check pixel (683,50) and (50,384) -> RGB=FFFFFF despite image/black background; pixel (683,780-blank region) -> RGB=000000 with DataEnable=0.
REQ-025 Assert rst_n low at (x=1380,y=771) mid-HSync and mid-VSync -> HSync=1, VSync=1, DE=0 immediately (asynchronous); after release, sequence identical to REQ-021 and img_addr restarts at 0.
